// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioning for the two intersection approaches: each raw input is
// synchronized, debounced, held over between cars, counted, and watched for a stuck sensor.

module vsc_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500_000,
  parameter int unsigned HOLD_CYCLES     = 32'd100_000_000,
  parameter int unsigned STUCK_CYCLES    = 32'd3_000_000_000,
  parameter int          CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_raw,
  input  logic             i_cnt_clr,
  output logic             o_req,
  output logic [CNT_W-1:0] o_car_cnt,
  output logic             o_fault
);

  localparam int DB_W    = $clog2(64'(DEBOUNCE_CYCLES) + 64'd1);
  localparam int HOLD_W  = $clog2(64'(HOLD_CYCLES) + 64'd1);
  localparam int STUCK_W = $clog2(64'(STUCK_CYCLES) + 64'd1);

  typedef enum logic [1:0] {
    ST_ABSENT  = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  logic               r_s1;
  logic               r_s2;
  logic               r_d;
  logic [DB_W-1:0]    r_db_cnt;
  state_t             r_state;
  logic               r_req;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [STUCK_W-1:0] r_stuck_cnt;
  logic [CNT_W-1:0]   r_car_cnt;
  logic               r_fault;

  logic w_arrive;
  logic w_stuck_hit;
  logic w_fault_next;

  // Sync the raw loop input, then flip the filtered level only after an unbroken disagreement run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_d      <= 1'b0;
      r_db_cnt <= {DB_W{1'b0}};
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 != r_d) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 32'd1)) begin
          r_d      <= r_s2;
          r_db_cnt <= {DB_W{1'b0}};
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1'b1);
        end
      end else begin
        r_db_cnt <= {DB_W{1'b0}};
      end
    end
  end

  // A new car is any rise of the filtered level seen while not already PRESENT.
  always_comb begin
    w_arrive     = 1'b0;
    w_stuck_hit  = 1'b0;
    w_fault_next = r_fault;
    if ((r_state == ST_ABSENT) || (r_state == ST_HOLD)) begin
      w_arrive = r_d;
    end else begin
      w_arrive = 1'b0;
    end
    if ((r_state == ST_PRESENT) && (r_stuck_cnt == STUCK_W'(STUCK_CYCLES - 32'd1))) begin
      w_stuck_hit = 1'b1;
    end else begin
      w_stuck_hit = 1'b0;
    end
    if (i_cnt_clr) begin
      w_fault_next = 1'b0;
    end else begin
      w_fault_next = r_fault | w_stuck_hit;
    end
  end

  // Presence FSM; the request is decoded from the next state and held high while faulted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_ABSENT;
      r_req      <= 1'b0;
      r_hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      case (r_state)
        ST_ABSENT: begin
          if (r_d) begin
            r_state <= ST_PRESENT;
            r_req   <= 1'b1;
          end else begin
            r_state <= ST_ABSENT;
            r_req   <= w_fault_next;
          end
        end
        ST_PRESENT: begin
          r_req <= 1'b1;
          if (!r_d) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= {HOLD_W{1'b0}};
          end else begin
            r_state <= ST_PRESENT;
          end
        end
        ST_HOLD: begin
          if (r_d) begin
            r_state <= ST_PRESENT;
            r_req   <= 1'b1;
          end else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 32'd1)) begin
            r_state <= ST_ABSENT;
            r_req   <= w_fault_next;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1'b1);
            r_req      <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_ABSENT;
          r_req      <= w_fault_next;
          r_hold_cnt <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  // Stuck timer saturates at its threshold so a long occupancy keeps re-raising the fault.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stuck_cnt <= {STUCK_W{1'b0}};
    end else if (r_state != ST_PRESENT) begin
      r_stuck_cnt <= {STUCK_W{1'b0}};
    end else if (!w_stuck_hit) begin
      r_stuck_cnt <= r_stuck_cnt + STUCK_W'(1'b1);
    end else begin
      r_stuck_cnt <= r_stuck_cnt;
    end
  end

  // Car counter and sticky fault; a clear beats a same-cycle increment or fault set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_car_cnt <= {CNT_W{1'b0}};
      r_fault   <= 1'b0;
    end else begin
      r_fault <= w_fault_next;
      if (i_cnt_clr) begin
        r_car_cnt <= {CNT_W{1'b0}};
      end else if (w_arrive && (r_car_cnt != {CNT_W{1'b1}})) begin
        r_car_cnt <= r_car_cnt + CNT_W'(1'b1);
      end else begin
        r_car_cnt <= r_car_cnt;
      end
    end
  end

  assign o_req     = r_req;
  assign o_car_cnt = r_car_cnt;
  assign o_fault   = r_fault;

endmodule

module vehicle_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500_000,
  parameter int unsigned HOLD_CYCLES     = 32'd100_000_000,
  parameter int unsigned STUCK_CYCLES    = 32'd3_000_000_000,
  parameter int          CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             cnt_clr,
  output logic             Sa,
  output logic             Sb,
  output logic [CNT_W-1:0] car_cnt_a,
  output logic [CNT_W-1:0] car_cnt_b,
  output logic             fault_a,
  output logic             fault_b
);

  vsc_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_a (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_raw     (raw_a),
    .i_cnt_clr (cnt_clr),
    .o_req     (Sa),
    .o_car_cnt (car_cnt_a),
    .o_fault   (fault_a)
  );

  vsc_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_b (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_raw     (raw_b),
    .i_cnt_clr (cnt_clr),
    .o_req     (Sb),
    .o_car_cnt (car_cnt_b),
    .o_fault   (fault_b)
  );

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Scoreboard bench: stimulus pushes timed expectations, a negedge monitor pops and checks them.

module tb_vehicle_sensor_conditioner;

  localparam int unsigned DB    = 32'd4;
  localparam int unsigned HOLD  = 32'd10;
  localparam int unsigned STUCK = 32'd50;
  localparam int          CW    = 8;

  localparam int SIG_SA = 0;
  localparam int SIG_SB = 1;
  localparam int SIG_CA = 2;
  localparam int SIG_CB = 3;
  localparam int SIG_FA = 4;
  localparam int SIG_FB = 5;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          raw_a;
  logic          raw_b;
  logic          cnt_clr;
  logic          Sa;
  logic          Sb;
  logic [CW-1:0] car_cnt_a;
  logic [CW-1:0] car_cnt_b;
  logic          fault_a;
  logic          fault_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .STUCK_CYCLES    (STUCK),
    .CNT_W           (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_a     (raw_a),
    .raw_b     (raw_b),
    .cnt_clr   (cnt_clr),
    .Sa        (Sa),
    .Sb        (Sb),
    .car_cnt_a (car_cnt_a),
    .car_cnt_b (car_cnt_b),
    .fault_a   (fault_a),
    .fault_b   (fault_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int obs_sig(input int s);
    case (s)
      SIG_SA:  return int'(Sa);
      SIG_SB:  return int'(Sb);
      SIG_CA:  return int'(car_cnt_a);
      SIG_CB:  return int'(car_cnt_b);
      SIG_FA:  return int'(fault_a);
      SIG_FB:  return int'(fault_b);
      default: return -1;
    endcase
  endfunction

  // Expect signal s to equal v after the k-th rising edge from now.
  function automatic void exp_at(input int k, input int s, input int v, input string tag);
    exp_t e;
    e.at  = cyc + k;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].at == cyc) begin
        check_val(sb_q[i].tag, obs_sig(sb_q[i].sig), sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    raw_a   = 1'b0;
    raw_b   = 1'b0;
    cnt_clr = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    raw_a   = 1'b0;
    raw_b   = 1'b0;
    cnt_clr = 1'b0;
    #2;
    reset_n = 1'b0;
    tick(2);
    check_val("rst_sa", int'(Sa), 0);
    check_val("rst_sb", int'(Sb), 0);
    check_val("rst_ca", int'(car_cnt_a), 0);
    check_val("rst_cb", int'(car_cnt_b), 0);
    check_val("rst_fa", int'(fault_a), 0);
    check_val("rst_fb", int'(fault_b), 0);
    reset_n = 1'b1;
    tick(2);

    // Rising latency on A; B untouched.
    raw_a = 1'b1;
    for (int k = 1; k <= 6; k++) exp_at(k, SIG_SA, 0, "lat_sa_low");
    exp_at(7, SIG_SA, 1, "lat_sa_rise");
    exp_at(6, SIG_CA, 0, "lat_ca_pre");
    exp_at(7, SIG_CA, 1, "lat_ca_one");
    for (int k = 1; k <= 10; k++) exp_at(k, SIG_SB, 0, "lat_sb_idle");
    exp_at(10, SIG_CB, 0, "lat_cb_idle");
    tick(12);

    // Glitches one cycle short of the debounce window are rejected.
    do_reset();
    for (int k = 1; k <= 40; k++) exp_at(k, SIG_SA, 0, "glitch_sa");
    exp_at(40, SIG_CA, 0, "glitch_ca");
    for (int r = 0; r < 5; r++) begin
      raw_a = 1'b1;
      tick(3);
      raw_a = 1'b0;
      tick(3);
    end
    tick(12);

    // Hold-over bridges a 6-cycle gap; final fall takes 4+2+11 edges.
    do_reset();
    for (int k = 7; k <= 62; k++) exp_at(k, SIG_SA, 1, "gap_sa_held");
    exp_at(6, SIG_SA, 0, "gap_sa_pre");
    exp_at(63, SIG_SA, 0, "gap_sa_fall");
    exp_at(20, SIG_CA, 1, "gap_ca_first");
    exp_at(63, SIG_CA, 2, "gap_ca_two");
    raw_a = 1'b1;
    tick(20);
    raw_a = 1'b0;
    tick(6);
    raw_a = 1'b1;
    tick(20);
    raw_a = 1'b0;
    tick(22);

    // Stuck sensor on B: fault at 50 PRESENT cycles, S held until cnt_clr.
    do_reset();
    exp_at(6,   SIG_SB, 0, "stk_sb_pre");
    exp_at(7,   SIG_SB, 1, "stk_sb_rise");
    exp_at(56,  SIG_FB, 0, "stk_fb_pre");
    exp_at(57,  SIG_FB, 1, "stk_fb_set");
    exp_at(60,  SIG_FA, 0, "stk_fa_idle");
    exp_at(130, SIG_SB, 1, "stk_sb_forced");
    exp_at(140, SIG_FB, 1, "stk_fb_sticky");
    exp_at(140, SIG_CB, 1, "stk_cb_one");
    exp_at(141, SIG_FB, 0, "stk_fb_clr");
    exp_at(141, SIG_CB, 0, "stk_cb_clr");
    exp_at(141, SIG_SB, 0, "stk_sb_clr");
    exp_at(150, SIG_SB, 0, "stk_sb_after");
    raw_b = 1'b1;
    tick(100);
    raw_b = 1'b0;
    tick(40);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    tick(12);

    // 300 cars saturate the counter at 255, then clear wins over a same-cycle arrival.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      raw_a = 1'b1;
      tick(20);
      raw_a = 1'b0;
      tick(20);
      if (i == 9) exp_at(1, SIG_CA, 10, "sat_ca_ten");
      if (i == 254 || i == 255 || i == 299) exp_at(1, SIG_CA, 255, "sat_ca_max");
    end
    tick(2);
    raw_a = 1'b1;
    exp_at(7,  SIG_SA, 1, "clr_sa_rise");
    exp_at(7,  SIG_CA, 0, "clr_ca_win");
    exp_at(12, SIG_CA, 0, "clr_ca_hold");
    tick(6);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    tick(6);
    raw_a = 1'b0;
    tick(20);
    raw_a = 1'b1;
    exp_at(6, SIG_CA, 0, "clr_ca_pre");
    exp_at(7, SIG_CA, 1, "clr_ca_recount");
    tick(10);

    // Async reset mid-debounce: immediate clear, then the full latency again.
    do_reset();
    raw_a = 1'b1;
    exp_at(7, SIG_SA, 1, "ar_sa_up");
    tick(20);
    raw_b = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #1;
    check_val("ar_sa_async", int'(Sa), 0);
    check_val("ar_sb_async", int'(Sb), 0);
    check_val("ar_ca_async", int'(car_cnt_a), 0);
    #1;
    reset_n = 1'b1;
    exp_at(6, SIG_SA, 0, "ar_sa_pre");
    exp_at(7, SIG_SA, 1, "ar_sa_rise");
    exp_at(6, SIG_SB, 0, "ar_sb_pre");
    exp_at(7, SIG_SB, 1, "ar_sb_rise");
    exp_at(7, SIG_CA, 1, "ar_ca_one");
    exp_at(7, SIG_CB, 1, "ar_cb_one");
    tick(10);

    check_val("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
